// File: rtl/fetch_queue_pkg.sv
// Shared constants for the decoupled instruction-fetch front end.
// Imported by the fetch queue, its bus interface and its FIFO sub-module.
package fetch_queue_pkg;

    localparam int          DEFAULT_DATA_W = 32;
    localparam int          DEFAULT_DEPTH  = 4;
    localparam logic [31:0] NOP_INST       = 32'h0000_0013;
    localparam int          FETCH_STEP     = 4;

endpackage

// File: rtl/fetch_queue_if.sv
// Bus bundle between the fetch queue, instruction memory, branch unit and IF_ID.
// The master modport is the fetch queue's view of the bus.
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) ();

    logic              imemReqValid;
    logic              imemReqReady;
    logic [DATA_W-1:0] imemReqAddr;
    logic              imemRespValid;
    logic [DATA_W-1:0] imemRespData;
    logic              redirectValid;
    logic [DATA_W-1:0] redirectAddr;
    logic              locker;
    logic              instValid;
    logic [DATA_W-1:0] instData;
    logic [DATA_W-1:0] instPc;

    modport master (
        output imemReqValid, imemReqAddr, instValid, instData, instPc,
        input  imemReqReady, imemRespValid, imemRespData,
        input  redirectValid, redirectAddr, locker
    );

    modport slave (
        input  imemReqValid, imemReqAddr, instValid, instData, instPc,
        output imemReqReady, imemRespValid, imemRespData,
        output redirectValid, redirectAddr, locker
    );

endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// Small synchronous FIFO with flush; head word is readable combinationally.
// Used for both the instruction queue and the request PC-tag queue.
module sync_fifo
    import fetch_queue_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_W,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wrData,
    output logic [WIDTH-1:0]       rdData,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic [PW:0]      cnt;
    logic             doPush;
    logic             doPop;

    assign full   = (cnt == (PW+1)'(DEPTH));
    assign empty  = (cnt == '0);
    assign count  = cnt;
    assign rdData = mem[rdPtr];
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: reads are only meaningful while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (doPush && !flush) mem[wrPtr] <= wrData;
    end

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch stage: owns the fetch PC, issues pipelined memory requests and
// buffers returned words with their PCs until IF_ID consumes them.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int                DATA_W   = DEFAULT_DATA_W,
    parameter int                DEPTH    = DEFAULT_DEPTH,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0]   fetchPc;
    logic [CW-1:0]       outstanding;
    logic [CW-1:0]       dropCnt;
    logic [CW-1:0]       qCount;
    logic [CW-1:0]       tagCount;
    logic [CW:0]         credit;
    logic [2*DATA_W-1:0] qHead;
    logic [DATA_W-1:0]   tagHead;
    logic                qEmpty;
    logic                qFull;
    logic                tagEmpty;
    logic                tagFull;
    logic                redirect;
    logic                reqValid;
    logic                reqFire;
    logic                respAccept;
    logic                respDrop;
    logic                respKeep;
    logic                popInst;
    logic                unusedStatus;

    // Queue entries plus in-flight requests never exceed DEPTH, so every response has a slot.
    assign redirect   = bus.redirectValid;
    assign credit     = {1'b0, qCount} + {1'b0, outstanding};
    assign reqValid   = reset && !redirect && !tagFull && (credit < (CW+1)'(DEPTH));
    assign reqFire    = reqValid && bus.imemReqReady;
    assign respAccept = bus.imemRespValid && (outstanding != '0);
    assign respDrop   = respAccept && (dropCnt != '0);
    assign respKeep   = respAccept && (dropCnt == '0) && !redirect && !tagEmpty && !qFull;
    assign popInst    = !qEmpty && !bus.locker && !redirect;
    assign unusedStatus = ^tagCount;

    assign bus.imemReqValid = reqValid;
    assign bus.imemReqAddr  = fetchPc;
    assign bus.instValid    = !qEmpty;
    assign bus.instData     = qEmpty ? DATA_W'(NOP_INST) : qHead[DATA_W-1:0];
    assign bus.instPc       = qEmpty ? '0 : qHead[2*DATA_W-1:DATA_W];

    // Tags for squashed requests are flushed on redirect; their responses are
    // accounted for by dropCnt alone and never pop the tag FIFO.
    sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) tagFifo (
        .clk    (clk),
        .reset  (reset),
        .flush  (redirect),
        .push   (reqFire),
        .pop    (respKeep),
        .wrData (fetchPc),
        .rdData (tagHead),
        .full   (tagFull),
        .empty  (tagEmpty),
        .count  (tagCount)
    );

    sync_fifo #(.WIDTH(2*DATA_W), .DEPTH(DEPTH)) instFifo (
        .clk    (clk),
        .reset  (reset),
        .flush  (redirect),
        .push   (respKeep),
        .pop    (popInst),
        .wrData ({tagHead, bus.imemRespData}),
        .rdData (qHead),
        .full   (qFull),
        .empty  (qEmpty),
        .count  (qCount)
    );

    // On redirect every in-flight request becomes a drop, less any response landing this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetchPc     <= RESET_PC;
            outstanding <= '0;
            dropCnt     <= '0;
        end else if (redirect) begin
            fetchPc     <= bus.redirectAddr;
            outstanding <= outstanding - CW'(respAccept);
            dropCnt     <= outstanding - CW'(respAccept);
        end else begin
            if (reqFire) fetchPc <= fetchPc + DATA_W'(FETCH_STEP);
            case ({reqFire, respAccept})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (respDrop) dropCnt <= dropCnt - 1'b1;
        end
    end

endmodule
